// File: rtl/fetcher_pkg.sv
// Shared scheduler/fetcher state codes and cache geometry helpers for the fetch stage.
package fetcher_pkg;

    localparam logic [2:0] SIMD_IDLE    = 3'd0;
    localparam logic [2:0] SIMD_FETCH   = 3'd1;
    localparam logic [2:0] SIMD_DECODE  = 3'd2;
    localparam logic [2:0] SIMD_REQUEST = 3'd3;
    localparam logic [2:0] SIMD_WAIT    = 3'd4;
    localparam logic [2:0] SIMD_EXECUTE = 3'd5;
    localparam logic [2:0] SIMD_UPDATE  = 3'd6;
    localparam logic [2:0] SIMD_DONE    = 3'd7;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'd0,
        FETCHER_FETCHING = 3'd1,
        FETCHER_FETCHED  = 3'd2
    } fetcher_state_e;

    // Tag width; a fully-indexed cache still keeps a 1-bit (constant zero) tag.
    function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                             input int unsigned lines);
        int unsigned idx;
        idx = $clog2(lines);
        return (addr_bits > idx) ? addr_bits - idx : 1;
    endfunction

endpackage

// File: rtl/fetch_cache.sv
// Direct-mapped instruction cache: combinational lookup, synchronous fill, one-cycle flush.
module fetch_cache
    import fetcher_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINES      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_BITS-1:0]  lookup_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  fill_en,
    input  logic [ADDR_BITS-1:0]  fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data
);

    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned TAG_BITS = tag_bits(ADDR_BITS, LINES);

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [TAG_BITS-1:0] fill_tag;

    assign lookup_idx = lookup_addr[IDX_BITS-1:0];
    assign fill_idx   = fill_addr[IDX_BITS-1:0];
    assign lookup_tag = TAG_BITS'(lookup_addr >> IDX_BITS);
    assign fill_tag   = TAG_BITS'(fill_addr >> IDX_BITS);

    assign hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign data = data_q[lookup_idx];

    // Flush beats a same-edge fill so no line survives an invalidate.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: cache lookup, program-memory handshake on miss, held instruction output.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int unsigned PROGRAM_ADDR_BITS = 8,
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned CACHE_LINES       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [2:0]                   simd_state,
    input  logic [PROGRAM_ADDR_BITS-1:0] pc,
    output logic                         mem_read_valid,
    output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_read_data,
    output logic [2:0]                   fetcher_state,
    output logic [INSTRUCTION_WIDTH-1:0] instruction
);

    fetcher_state_e state;
    // Set when a flush lands while a request is outstanding; blocks the later fill.
    logic           squash;

    logic                         cache_hit;
    logic [INSTRUCTION_WIDTH-1:0] cache_data;
    logic                         fill_en;

    assign fill_en = enable && (state == FETCHER_FETCHING) && mem_read_ready && !flush
                     && !squash;

    fetch_cache #(
        .ADDR_BITS  (PROGRAM_ADDR_BITS),
        .DATA_WIDTH (INSTRUCTION_WIDTH),
        .LINES      (CACHE_LINES)
    ) u_cache (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .lookup_addr (pc),
        .hit         (cache_hit),
        .data        (cache_data),
        .fill_en     (fill_en),
        .fill_addr   (mem_read_address),
        .fill_data   (mem_read_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= FETCHER_IDLE;
            squash           <= 1'b0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
        end else begin
            // Flush is honoured even while the block is disabled.
            if (flush && state == FETCHER_FETCHING) begin
                squash <= 1'b1;
            end
            if (enable) begin
                case (state)
                    FETCHER_IDLE: begin
                        if (simd_state == SIMD_FETCH) begin
                            if (cache_hit && !flush) begin
                                instruction <= cache_data;
                                state       <= FETCHER_FETCHED;
                            end else begin
                                mem_read_valid   <= 1'b1;
                                mem_read_address <= pc;
                                squash           <= 1'b0;
                                state            <= FETCHER_FETCHING;
                            end
                        end
                    end
                    FETCHER_FETCHING: begin
                        if (mem_read_ready) begin
                            instruction    <= mem_read_data;
                            mem_read_valid <= 1'b0;
                            state          <= FETCHER_FETCHED;
                        end
                    end
                    FETCHER_FETCHED: begin
                        if (simd_state == SIMD_DECODE) begin
                            state <= FETCHER_IDLE;
                        end
                    end
                    default: state <= FETCHER_IDLE;
                endcase
            end
        end
    end

    assign fetcher_state = state;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: vector table, corner-case sequences and random traffic vs a cache model.
module tb_fetcher;
    import fetcher_pkg::*;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned LINES = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic [2:0]    simd_state;
    logic [AW-1:0] pc;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;

    int checks   = 0;
    int failures = 0;

    // Reference cache: which PC each line holds, and its word.
    bit            m_valid [LINES];
    logic [AW-1:0] m_pc    [LINES];
    logic [DW-1:0] m_data  [LINES];
    logic [DW-1:0] exp_instr;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            lat;
        bit            hit;
    } vec_t;

    vec_t vecs [7];

    fetcher #(
        .PROGRAM_ADDR_BITS (AW),
        .INSTRUCTION_WIDTH (DW),
        .CACHE_LINES       (LINES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .flush            (flush),
        .simd_state       (simd_state),
        .pc               (pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [AW-1:0] a);
        int i;
        i = int'(a) % LINES;
        return m_valid[i] && (m_pc[i] == a);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    // One complete fetch/decode round trip. fl_cyc >= 0 pulses flush on that wait cycle.
    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d, input int lat,
                         input bit exp_hit, input bit fl_lookup, input int fl_cyc,
                         input string nm);
        int i;
        i = int'(a) % LINES;
        simd_state = SIMD_FETCH;
        pc         = a;
        flush      = fl_lookup;
        step();
        flush      = 1'b0;
        if (fl_lookup) model_clear();
        simd_state = SIMD_WAIT;
        pc         = AW'($urandom);
        if (exp_hit) begin
            check({nm, " hit state"}, 64'(fetcher_state), 64'(FETCHER_FETCHED));
            check({nm, " hit no req"}, 64'(mem_read_valid), 64'd0);
            exp_instr = d;
            check({nm, " hit instr"}, 64'(instruction), 64'(exp_instr));
        end else begin
            check({nm, " req state"}, 64'(fetcher_state), 64'(FETCHER_FETCHING));
            check({nm, " req valid"}, 64'(mem_read_valid), 64'd1);
            check({nm, " req addr"}, 64'(mem_read_address), 64'(a));
            for (int c = 0; c < lat; c++) begin
                mem_read_ready = (c == lat - 1);
                mem_read_data  = mem_read_ready ? d : DW'($urandom);
                flush          = (c == fl_cyc);
                step();
                if (flush) model_clear();
                flush          = 1'b0;
                mem_read_ready = 1'b0;
                mem_read_data  = DW'($urandom);
                if (c < lat - 1) begin
                    check({nm, " wait valid"}, 64'(mem_read_valid), 64'd1);
                    check({nm, " wait addr"}, 64'(mem_read_address), 64'(a));
                    check({nm, " wait instr"}, 64'(instruction), 64'(exp_instr));
                end
            end
            exp_instr = d;
            check({nm, " fill instr"}, 64'(instruction), 64'(exp_instr));
            check({nm, " fill state"}, 64'(fetcher_state), 64'(FETCHER_FETCHED));
            check({nm, " fill valid"}, 64'(mem_read_valid), 64'd0);
            if (fl_cyc < 0) begin
                m_valid[i] = 1'b1;
                m_pc[i]    = a;
                m_data[i]  = d;
            end
        end
        simd_state = SIMD_DECODE;
        step();
        simd_state = SIMD_IDLE;
        check({nm, " decode idle"}, 64'(fetcher_state), 64'(FETCHER_IDLE));
        check({nm, " decode instr"}, 64'(instruction), 64'(exp_instr));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; flush = 1'b0; simd_state = SIMD_IDLE; pc = '0;
        mem_read_ready = 1'b0; mem_read_data = '0;
        model_clear();
        exp_instr = '0;
        step();
        step();
        check("reset state", 64'(fetcher_state), 64'(FETCHER_IDLE));
        check("reset valid", 64'(mem_read_valid), 64'd0);
        check("reset addr", 64'(mem_read_address), 64'd0);
        check("reset instr", 64'(instruction), 64'd0);
        rst = 1'b0;
        step();

        // Cold miss, hit, conflicts on index 1, then re-hit.
        vecs[0] = '{addr: 8'h05, data: 32'h0C123456, lat: 3, hit: 1'b0};
        vecs[1] = '{addr: 8'h05, data: 32'h0C123456, lat: 1, hit: 1'b1};
        vecs[2] = '{addr: 8'h09, data: 32'h11110009, lat: 1, hit: 1'b0};
        vecs[3] = '{addr: 8'h05, data: 32'h0C123456, lat: 2, hit: 1'b0};
        vecs[4] = '{addr: 8'h05, data: 32'h0C123456, lat: 1, hit: 1'b1};
        vecs[5] = '{addr: 8'h0D, data: 32'h2222000D, lat: 4, hit: 1'b0};
        vecs[6] = '{addr: 8'h09, data: 32'h11110009, lat: 1, hit: 1'b0};
        foreach (vecs[k]) begin
            fetch(vecs[k].addr, vecs[k].data, vecs[k].lat, vecs[k].hit, 1'b0, -1,
                  $sformatf("vec%0d", k));
        end

        // Flush while the request is outstanding: data delivered, line not filled.
        fetch(8'h07, 32'hABCD0001, 3, 1'b0, 1'b0, 1, "flush mid");
        fetch(8'h07, 32'hABCD0001, 1, 1'b0, 1'b0, -1, "post flush miss");
        fetch(8'h07, 32'hABCD0001, 1, 1'b1, 1'b0, -1, "refill hit");
        fetch(8'h07, 32'hABCD0001, 1, 1'b0, 1'b1, -1, "flush lookup");

        // Reset mid-fetch, then a late ready must be ignored.
        simd_state = SIMD_FETCH; pc = 8'h22;
        step();
        simd_state = SIMD_WAIT;
        check("rst pre valid", 64'(mem_read_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        exp_instr = '0;
        mem_read_ready = 1'b1; mem_read_data = 32'hDEADBEEF;
        step();
        mem_read_ready = 1'b0;
        check("rst state", 64'(fetcher_state), 64'(FETCHER_IDLE));
        check("rst valid", 64'(mem_read_valid), 64'd0);
        check("rst addr", 64'(mem_read_address), 64'd0);
        check("rst instr", 64'(instruction), 64'd0);
        simd_state = SIMD_IDLE;
        fetch(8'h05, 32'h0C123456, 1, 1'b0, 1'b0, -1, "post rst miss");

        // Enable low for 4 cycles with ready held high: nothing moves.
        simd_state = SIMD_FETCH; pc = 8'h33;
        step();
        simd_state = SIMD_WAIT;
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 32'h5555AAAA;
        for (int c = 0; c < 4; c++) begin
            step();
            check("dis state", 64'(fetcher_state), 64'(FETCHER_FETCHING));
            check("dis valid", 64'(mem_read_valid), 64'd1);
            check("dis instr", 64'(instruction), 64'(exp_instr));
        end
        enable = 1'b1;
        step();
        mem_read_ready = 1'b0;
        exp_instr = 32'h5555AAAA;
        m_valid[3] = 1'b1; m_pc[3] = 8'h33; m_data[3] = 32'h5555AAAA;
        check("en capture", 64'(instruction), 64'(exp_instr));
        check("en state", 64'(fetcher_state), 64'(FETCHER_FETCHED));
        simd_state = SIMD_DECODE;
        step();
        simd_state = SIMD_IDLE;
        check("en decode", 64'(fetcher_state), 64'(FETCHER_IDLE));
        fetch(8'h33, 32'h5555AAAA, 1, 1'b1, 1'b0, -1, "en refetch hit");

        // Random traffic against the reference cache.
        for (int t = 0; t < 300; t++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            bit            h;
            bit            fl;
            int            lat;
            int            fc;
            a   = AW'($urandom_range(0, 15));
            fl  = ($urandom_range(0, 15) == 0);
            h   = model_hit(a) && !fl;
            lat = $urandom_range(1, 4);
            fc  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, lat - 1) : -1;
            d   = h ? m_data[int'(a) % LINES] : DW'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                model_clear();
                h = 1'b0;
                if (!fl) d = DW'($urandom);
            end
            fetch(a, d, lat, h, fl, h ? -1 : fc, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage for a SIMD core, sitting directly upstream of the decoder. When the core scheduler enters the fetch state, the fetcher reads the instruction at the current PC, either from a small direct-mapped instruction cache or from program memory over a valid/ready handshake. It holds the instruction stable on `instruction` for the decoder and reports progress to the scheduler through `fetcher_state`.

## Interface
- `PROGRAM_ADDR_BITS`, default 8: program memory address width (PC width).
- `INSTRUCTION_WIDTH`, default 32: instruction word width.
- `CACHE_LINES`, default 4: number of direct-mapped cache lines; must be a power of two, ≥2 and ≤ 2^PROGRAM_ADDR_BITS.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  block active; when low, all state and outputs hold.
- `flush`  in  1  one-cycle pulse; invalidates every cache line (kernel launch / program reload).
- `simd_state`  in  3  core scheduler state (`SIMD_FETCH`, `SIMD_DECODE`, …).
- `pc`  in  PROGRAM_ADDR_BITS  address to fetch; sampled only when a fetch starts.
- `mem_read_valid`  out  1  program-memory read request.
- `mem_read_address`  out  PROGRAM_ADDR_BITS  request address.
- `mem_read_ready`  in  1  memory has returned `mem_read_data`.
- `mem_read_data`  in  INSTRUCTION_WIDTH  returned instruction word.
- `fetcher_state`  out  3  `FETCHER_IDLE`, `FETCHER_FETCHING` or `FETCHER_FETCHED`.
- `instruction`  out  INSTRUCTION_WIDTH  last fetched instruction; consumed by the decoder.

## Operation
- Reset values: `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0, all cache valid bits 0.
- Cache: index = `pc[log2(CACHE_LINES)-1:0]`; tag = remaining upper PC bits. Each line holds a valid bit, a tag and a data word.
- IDLE with `simd_state==SIMD_FETCH`:
  - Hit (line valid, tags match, `flush` low): load `instruction` from the line and go to FETCHED. No memory request is issued.
  - Miss: set `mem_read_valid`=1 and `mem_read_address`=`pc`, then go to FETCHING.
- FETCHING: on `mem_read_ready`=1, load `instruction` from `mem_read_data`, clear `mem_read_valid`, fill the line (valid=1, tag, data), then go to FETCHED. `mem_read_valid` and `mem_read_address` stay constant until `mem_read_ready` is seen.
- FETCHED: hold. On `simd_state==SIMD_DECODE`, go to IDLE. `instruction` is unchanged until the next fetch completes.
- `mem_read_ready` outside FETCHING is ignored.
- Flush:
  - Clears all valid bits at the edge where it is sampled.
  - Flush coincident with a lookup makes that lookup a miss.
  - Flush during FETCHING: the in-flight response still reaches `instruction`, but the response is not written into the cache.
- `enable` low: no state change, no cache change, and `mem_read_valid` holds its value. `flush` is still honoured.
- `rst` mid-transaction: everything returns to reset values on the next edge and the outstanding request is abandoned. A late `mem_read_ready` is ignored.

## Timing
- Hit: `SIMD_FETCH` is sampled at edge N. After edge N, `fetcher_state`=FETCHED and `instruction` is valid (1-cycle latency).
- Miss: `mem_read_valid` rises after edge N. `mem_read_ready` is sampled no earlier than edge N+1. When it is sampled at edge M, `instruction` is valid and `fetcher_state`=FETCHED after M. Minimum miss latency is 2 cycles.
- A line filled at edge M can be hit by a lookup at edge M+1 or later.
- FETCHED→IDLE takes one edge after `SIMD_DECODE` is sampled. The decoder latches `instruction` during `SIMD_DECODE`, which is guaranteed stable then.

## Structure
- Add `FETCHER_IDLE`=3'd0, `FETCHER_FETCHING`=3'd1 and `FETCHER_FETCHED`=3'd2 to `common_defs.v`, next to the existing `SIMD_*` codes.
- Sub-module `fetch_cache` holds the valid/tag/data arrays:
  - combinational lookup: `hit`, `data`;
  - synchronous fill port;
  - `flush` input.
- The FSM and handshake stay in `fetcher`.

## Test plan
- Cold miss: after reset, `pc`=0x05 with `SIMD_FETCH`; memory returns 0x0C123456 after 3 cycles. Required: `mem_read_valid`=1 with address 0x05 until ready; `instruction`=0x0C123456; state FETCHED; then IDLE after `SIMD_DECODE`.
- Hit: refetch `pc`=0x05. Required: FETCHED after 1 edge, `mem_read_valid` never asserted, `instruction`=0x0C123456.
- Conflict: with CACHE_LINES=4, fetch 0x05 and then 0x09 (same index, different tag), then fetch 0x05 again. Required: all three fetches miss and issue memory requests.
- Flush during FETCHING for `pc`=0x07 (data 0xABCD0001). Required: `instruction`=0xABCD0001, and a subsequent fetch of 0x07 misses.
- Reset mid-fetch: assert `rst` while FETCHING, then pulse `mem_read_ready`. Required: state IDLE, `mem_read_valid`=0, `instruction`=0, ready ignored.
- `enable` low for 4 cycles during FETCHING, with `mem_read_ready` held high throughout. Required: outputs frozen and no capture; capture occurs on the first enabled edge.
